// File: rtl/btb_update_ctrl.sv
// BTB update scheduler: queues mispredict corrections from two branch units,
// merges same-PC requests and drains one per cycle into the BTB write port.
module btb_update_ctrl #(
    parameter int QDEPTH = 4,
    parameter int CNTW   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      upd0_valid,
    input  logic [31:0]               upd0_pc,
    input  logic [31:0]               upd0_target,
    input  logic [2:0]                upd0_type,
    input  logic                      upd1_valid,
    input  logic [31:0]               upd1_pc,
    input  logic [31:0]               upd1_target,
    input  logic [2:0]                upd1_type,
    input  logic                      btb_ready,
    output logic                      branch_mistaken,
    output logic [31:0]               wrong_pc,
    output logic [31:0]               right_target,
    output logic [2:0]                ins_type_w,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic [CNTW-1:0]           drop_cnt
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);

    logic [31:0]   q_pc  [QDEPTH];
    logic [31:0]   q_tgt [QDEPTH];
    logic [2:0]    q_typ [QDEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          pop;
    logic [CW-1:0] room;
    logic [QDEPTH-1:0] live;
    logic [PW-1:0] rel;

    logic          hit0;
    logic          hit1;
    logic [PW-1:0] idx0;
    logic [PW-1:0] idx1;
    logic          wr0;
    logic          wr1;
    logic          alloc0;
    logic          alloc1;
    logic [PW-1:0] slot0;
    logic [PW-1:0] slot1;
    logic [1:0]    drops;
    logic [CNTW:0] dsum;

    // A slot is live if it holds an entry that survives this cycle's pop.
    always_comb begin
        pop  = (count != '0) && btb_ready;
        room = count - CW'(pop);
        live = '0;
        rel  = '0;
        hit0 = 1'b0;
        hit1 = 1'b0;
        idx0 = '0;
        idx1 = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            rel = PW'(i) - head;
            live[i] = ({1'b0, rel} < count) && !((rel == '0) && pop);
            if (live[i] && (q_pc[i] == upd0_pc)) begin
                hit0 = 1'b1;
                idx0 = PW'(i);
            end
            if (live[i] && (q_pc[i] == upd1_pc)) begin
                hit1 = 1'b1;
                idx1 = PW'(i);
            end
        end
    end

    always_comb begin
        wr0    = 1'b0;
        wr1    = 1'b0;
        alloc0 = 1'b0;
        alloc1 = 1'b0;
        slot0  = '0;
        slot1  = '0;
        drops  = '0;
        if (upd0_valid) begin
            if (hit0) begin
                wr0   = 1'b1;
                slot0 = idx0;
            end else if (room < FULL) begin
                wr0    = 1'b1;
                alloc0 = 1'b1;
                slot0  = tail;
            end else begin
                drops = drops + 2'd1;
            end
        end
        // Unit 1 lands on unit 0's slot when PCs match, so it wins the write.
        if (upd1_valid) begin
            if (wr0 && (upd1_pc == upd0_pc)) begin
                wr1   = 1'b1;
                slot1 = slot0;
            end else if (hit1) begin
                wr1   = 1'b1;
                slot1 = idx1;
            end else if ((room + CW'(alloc0)) < FULL) begin
                wr1    = 1'b1;
                alloc1 = 1'b1;
                slot1  = tail + PW'(alloc0);
            end else begin
                drops = drops + 2'd1;
            end
        end
        dsum = {1'b0, drop_cnt} + (CNTW+1)'(drops);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            if (pop)
                head <= head + PW'(1);
            tail  <= tail + PW'(alloc0) + PW'(alloc1);
            count <= room + CW'(alloc0) + CW'(alloc1);
            drop_cnt <= dsum[CNTW] ? '1 : dsum[CNTW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wr0) begin
                q_pc[slot0]  <= upd0_pc;
                q_tgt[slot0] <= upd0_target;
                q_typ[slot0] <= upd0_type;
            end
            if (wr1) begin
                q_pc[slot1]  <= upd1_pc;
                q_tgt[slot1] <= upd1_target;
                q_typ[slot1] <= upd1_type;
            end
        end
    end

    assign branch_mistaken = pop;
    assign wrong_pc        = (count != '0) ? q_pc[head]  : '0;
    assign right_target    = (count != '0) ? q_tgt[head] : '0;
    assign ins_type_w      = (count != '0) ? q_typ[head] : '0;
    assign q_count         = count;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: directed pushes, monitor checks
// every drained update against hand-computed expectations.
module tb_btb_update_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        upd0_valid, upd1_valid;
    logic [31:0] upd0_pc, upd0_target, upd1_pc, upd1_target;
    logic [2:0]  upd0_type, upd1_type;
    logic        btb_ready;
    logic        branch_mistaken;
    logic [31:0] wrong_pc, right_target;
    logic [2:0]  ins_type_w;
    logic [2:0]  q_count;
    logic [15:0] drop_cnt;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [2:0]  ty;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    btb_update_ctrl #(.QDEPTH(4), .CNTW(16)) dut (
        .clk(clk), .reset(reset),
        .upd0_valid(upd0_valid), .upd0_pc(upd0_pc),
        .upd0_target(upd0_target), .upd0_type(upd0_type),
        .upd1_valid(upd1_valid), .upd1_pc(upd1_pc),
        .upd1_target(upd1_target), .upd1_type(upd1_type),
        .btb_ready(btb_ready),
        .branch_mistaken(branch_mistaken), .wrong_pc(wrong_pc),
        .right_target(right_target), .ins_type_w(ins_type_w),
        .q_count(q_count), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_upd(input logic [31:0] pc, input logic [31:0] tgt,
                              input logic [2:0] ty);
        exp_t e;
        e.pc = pc;
        e.tgt = tgt;
        e.ty = ty;
        sbq.push_back(e);
    endtask

    task automatic set0(input logic [31:0] pc, input logic [31:0] tgt,
                        input logic [2:0] ty);
        upd0_valid = 1'b1;
        upd0_pc = pc;
        upd0_target = tgt;
        upd0_type = ty;
    endtask

    task automatic set1(input logic [31:0] pc, input logic [31:0] tgt,
                        input logic [2:0] ty);
        upd1_valid = 1'b1;
        upd1_pc = pc;
        upd1_target = tgt;
        upd1_type = ty;
    endtask

    task automatic clr();
        upd0_valid = 1'b0;
        upd1_valid = 1'b0;
    endtask

    // Monitor: every strobe must match the oldest expected update.
    always @(negedge clk) begin
        if (!reset && branch_mistaken) begin
            exp_t e;
            tests++;
            if (sbq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_update: got pc 0x%0h, none expected",
                         wrong_pc);
            end else begin
                e = sbq.pop_front();
                if (wrong_pc !== e.pc || right_target !== e.tgt ||
                    ins_type_w !== e.ty) begin
                    fails++;
                    $display("FAIL drain: got %0h/%0h/%0d expected %0h/%0h/%0d",
                             wrong_pc, right_target, ins_type_w,
                             e.pc, e.tgt, e.ty);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        btb_ready = 1'b0;
        upd0_pc = '0; upd0_target = '0; upd0_type = '0;
        upd1_pc = '0; upd1_target = '0; upd1_type = '0;
        clr();
        tick();
        tick();
        check("reset_strobe", 32'(branch_mistaken), 0);
        check("reset_count", 32'(q_count), 0);
        check("reset_drop", 32'(drop_cnt), 0);
        check("reset_pc", wrong_pc, 0);
        reset = 1'b0;
        tick();

        // Single request, one-cycle latency
        btb_ready = 1'b1;
        set0(32'h1c000100, 32'h1c000200, 3'd3);
        expect_upd(32'h1c000100, 32'h1c000200, 3'd3);
        #1;
        check("no_bypass", 32'(branch_mistaken), 0);
        tick();
        clr();
        check("single_count", 32'(q_count), 1);
        tick();
        check("single_done_strobe", 32'(branch_mistaken), 0);
        check("single_done_count", 32'(q_count), 0);

        // Dual issue, distinct PCs
        set0(32'h100, 32'h1100, 3'd1);
        set1(32'h104, 32'h1104, 3'd2);
        expect_upd(32'h100, 32'h1100, 3'd1);
        expect_upd(32'h104, 32'h1104, 3'd2);
        tick();
        clr();
        tick();
        tick();
        check("dual_count", 32'(q_count), 0);

        // Merge across cycles
        btb_ready = 1'b0;
        set0(32'h200, 32'hA00, 3'd1);
        tick();
        set0(32'h300, 32'hC00, 3'd2);
        tick();
        set0(32'h200, 32'hB00, 3'd4);
        tick();
        clr();
        check("merge_count", 32'(q_count), 2);
        expect_upd(32'h200, 32'hB00, 3'd4);
        expect_upd(32'h300, 32'hC00, 3'd2);
        btb_ready = 1'b1;
        tick();
        tick();
        check("merge_drained", 32'(q_count), 0);

        // Same-PC pair in one cycle
        btb_ready = 1'b0;
        set0(32'h400, 32'h111, 3'd5);
        set1(32'h400, 32'h222, 3'd6);
        tick();
        clr();
        check("pair_count", 32'(q_count), 1);
        expect_upd(32'h400, 32'h222, 3'd6);
        btb_ready = 1'b1;
        tick();
        check("pair_drained", 32'(q_count), 0);

        // Overflow with a stalled BTB
        btb_ready = 1'b0;
        set0(32'h500, 32'h1500, 3'd0);
        set1(32'h504, 32'h1504, 3'd1);
        tick();
        set0(32'h508, 32'h1508, 3'd2);
        set1(32'h50c, 32'h150c, 3'd3);
        tick();
        set0(32'h600, 32'h1600, 3'd4);
        set1(32'h604, 32'h1604, 3'd5);
        tick();
        clr();
        check("ovf_drop", 32'(drop_cnt), 2);
        check("ovf_count", 32'(q_count), 4);
        expect_upd(32'h500, 32'h1500, 3'd0);
        expect_upd(32'h504, 32'h1504, 3'd1);
        expect_upd(32'h508, 32'h1508, 3'd2);
        expect_upd(32'h50c, 32'h150c, 3'd3);
        btb_ready = 1'b1;
        repeat (4) tick();
        check("ovf_drained", 32'(q_count), 0);

        // Full queue with a simultaneous pop: one push fits
        btb_ready = 1'b0;
        set0(32'h700, 32'h1700, 3'd1);
        set1(32'h704, 32'h1704, 3'd2);
        tick();
        set0(32'h708, 32'h1708, 3'd3);
        set1(32'h70c, 32'h170c, 3'd4);
        tick();
        expect_upd(32'h700, 32'h1700, 3'd1);
        expect_upd(32'h704, 32'h1704, 3'd2);
        expect_upd(32'h708, 32'h1708, 3'd3);
        expect_upd(32'h70c, 32'h170c, 3'd4);
        expect_upd(32'h800, 32'h1800, 3'd7);
        btb_ready = 1'b1;
        set0(32'h800, 32'h1800, 3'd7);
        set1(32'h804, 32'h1804, 3'd6);
        tick();
        clr();
        check("popfull_drop", 32'(drop_cnt), 3);
        check("popfull_count", 32'(q_count), 4);
        repeat (4) tick();
        check("popfull_drained", 32'(q_count), 0);

        // Reset mid-drain discards pending entries
        btb_ready = 1'b0;
        set0(32'h900, 32'h1900, 3'd1);
        set1(32'h904, 32'h1904, 3'd2);
        tick();
        set0(32'h908, 32'h1908, 3'd3);
        tick();
        clr();
        check("pre_reset_count", 32'(q_count), 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        btb_ready = 1'b1;
        #1;
        check("rst_strobe", 32'(branch_mistaken), 0);
        check("rst_count", 32'(q_count), 0);
        check("rst_drop", 32'(drop_cnt), 0);
        tick();
        check("rst_strobe_later", 32'(branch_mistaken), 0);

        tick();
        check("sb_empty", 32'(sbq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/btb_update_ctrl.md
Name: btb_update_ctrl

Overview:
Update scheduler for the branch target buffer's single write port. Accepts mispredict-correction requests from the two execute-stage branch units in the dual-issue pipeline. Buffers them in a small in-order queue, merging requests that carry the same PC. Drains one request per cycle into the BTB update interface (branch_mistaken / ins_type_w / wrong_pc / right_target).

Parameters:
QDEPTH, 4, number of queue slots (power of two, >= 2)
CNTW, 16, width of the saturating drop counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
upd0_valid  in  1  branch unit 0 reports a mispredict this cycle
upd0_pc  in  32  PC of mispredicted branch, unit 0
upd0_target  in  32  correct target, unit 0
upd0_type  in  3  instruction type, unit 0
upd1_valid  in  1  branch unit 1 reports a mispredict (program-younger than unit 0)
upd1_pc  in  32  PC, unit 1
upd1_target  in  32  correct target, unit 1
upd1_type  in  3  instruction type, unit 1
btb_ready  in  1  BTB write port accepts an update this cycle
branch_mistaken  out  1  update strobe to BTB
wrong_pc  out  32  PC to BTB
right_target  out  32  target to BTB
ins_type_w  out  3  type to BTB
q_count  out  $clog2(QDEPTH)+1  current occupancy
drop_cnt  out  CNTW  saturating count of discarded requests

Behaviour:
- Reset (sync): queue empty; head/tail pointers 0; q_count=0; drop_cnt=0.
- Outputs are driven combinationally from the head slot:
  - branch_mistaken = (q_count!=0) && btb_ready.
  - wrong_pc / right_target / ins_type_w = head fields, or 0 when the queue is empty.
  - During and right after reset all outputs are 0.
- Pop: the head retires in the cycle branch_mistaken=1. The head is held unchanged while btb_ready=0.
- Latency: a request accepted in cycle N appears at the outputs no earlier than cycle N+1. There is no same-cycle bypass.
- Per-cycle order of evaluation: pop, then unit 0, then unit 1.
- Coalescing:
  - Compare each incoming PC (full 32 bits) against every valid slot, excluding the head when it pops this cycle.
  - On a match, overwrite that slot's target and type in place. No new slot is allocated and queue position is kept.
  - If both units are valid with equal PCs, unit 1's target and type win, and at most one slot is consumed.
- Allocation: a non-merged request takes the tail slot if a slot is free after this cycle's pop. Unit 0 is allocated before unit 1.
- Full:
  - A request that neither merges nor finds a free slot is discarded.
  - drop_cnt increases by the number discarded this cycle (0, 1 or 2) and saturates at 2^CNTW-1.
  - Discards never disturb queue contents.
- Simultaneous pop and push with a full queue: the freed slot is usable, so one push succeeds.
- Pointers wrap modulo QDEPTH. q_count is next = current - pop + allocations, and is never > QDEPTH.
- Reset asserted mid-operation: all pending updates are discarded and branch_mistaken=0 the next cycle. Dropping BTB hints is architecturally harmless.
- No back-pressure to the branch units. Requests are hints and loss is accepted, but counted.

Test Plan:
- Single request: reset, then upd0 {pc=0x1c000100, tgt=0x1c000200, type=3}, btb_ready=1.
  - Response: cycle+1 has branch_mistaken=1 with those values.
  - Cycle+2 has branch_mistaken=0 and q_count=0.
- Dual issue, distinct PCs: pc 0x100 (unit 0) and 0x104 (unit 1) in the same cycle, btb_ready=1.
  - Response: 0x100 drains first, then 0x104 in the next cycle.
- Merge: with btb_ready=0, push pc 0x200 tgt 0xA00, then pc 0x300, then pc 0x200 tgt 0xB00.
  - Response: q_count=2.
  - After ready rises, outputs are 0x200/0xB00, then 0x300.
- Same-PC pair: both units push pc 0x400, tgt 0x111 (unit 0) and 0x222 (unit 1).
  - Response: q_count=1; drained target is 0x222.
- Overflow: btb_ready=0, fill 4 distinct PCs, then push 2 new distinct PCs in one cycle.
  - Response: drop_cnt=2, q_count=4, and the original 4 drain in order.
  - Repeat with btb_ready=1 at the time of the pushes: one is accepted, drop_cnt +1.
- Reset mid-drain: 3 entries queued, assert reset for 1 cycle.
  - Response: branch_mistaken=0, q_count=0 and drop_cnt=0 on the following cycle.
